// File: rtl/window_ram_pkg.sv
// window_ram_pkg: shared types and helpers for the multi-bank window RAM.
// Holds the read FSM state encoding, the bank-count calculation and the
// window address helper. The helper returns 32 bits; callers truncate the
// result to ADDR_W so that windows wrap modulo the memory depth.
package window_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of replica banks needed so that every output word has its own read port.
    function automatic int n_bank_f(input int n_out, input int rd_per_bank);
        return (n_out + rd_per_bank - 1) / rd_per_bank;
    endfunction

    // Address of output word idx: base + idx*stride. The caller truncates the result.
    function automatic logic [31:0] win_offset(input logic [31:0] base,
                                               input logic [31:0] stride,
                                               input logic [31:0] idx);
        return base + idx * stride;
    endfunction

endpackage

// File: rtl/window_ram_bank.sv
// window_ram_bank: one replica of the logical memory.
// It has one write port and N_RD registered read ports, all sharing one clock.
// Reads are read-first: a same-edge write to the read address is seen only
// by later reads. The memory array itself is never reset. The read output
// registers clear on i_rst.
module window_ram_bank
    import window_ram_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int N_RD   = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    input  logic [N_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [N_RD*DATA_W-1:0]   o_rd_data
);

    logic [DATA_W-1:0]      r_mem [2**ADDR_W];
    logic [N_RD*DATA_W-1:0] r_rd_data;

    // Write port: the caller gates i_wr_en during reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read ports. Non-blocking assignments give read-first behaviour against the write port.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            for (int p = 0; p < N_RD; p++) begin
                r_rd_data[p*DATA_W +: DATA_W] <= r_mem[i_rd_addr[p*ADDR_W +: ADDR_W]];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/window_ram.sv
// window_ram: a window read of N_OUT words from a replicated multi-bank RAM.
// The IDLE -> READ -> DONE sequence runs once per accepted request.
// On acceptance the N_OUT word addresses are latched. In READ every bank
// reads its share in parallel straight into the data_out registers. DONE
// raises ready for one cycle.
// Handshake: rd_en is taken only while IDLE (busy low), and a request seen
// while busy is dropped. ready pulses for exactly one cycle when data_out
// holds the window of the last accepted request. data_out keeps that value
// until the next READ cycle.
// Optional feature: define WINDOW_RAM_STRIDE_EN to add the rd_stride port.
// Without it the window is contiguous (stride 1).
module window_ram
    import window_ram_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 9,
    parameter int N_OUT       = 12,
    parameter int RD_PER_BANK = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
`ifdef WINDOW_RAM_STRIDE_EN
    input  logic [ADDR_W-1:0]       rd_stride,
`endif
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    output logic [N_OUT*DATA_W-1:0] data_out,
    output logic                    ready,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int N_BANK = n_bank_f(N_OUT, RD_PER_BANK);
    localparam int N_PORT = N_BANK * RD_PER_BANK;

    localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
    localparam logic [1:0] S_READ = 2'(ST_READ);
    localparam logic [1:0] S_DONE = 2'(ST_DONE);

    logic [1:0]               r_state;
    logic                     r_ready;
    logic                     r_busy;
    logic [ADDR_W-1:0]        r_addr [N_PORT];
    logic [ADDR_W-1:0]        w_stride;
    logic                     w_accept;
    logic                     w_wr_en;
    logic                     w_rd_en;
    logic [N_PORT*ADDR_W-1:0] w_rd_addr;
    logic [N_PORT*DATA_W-1:0] w_rd_data;

`ifdef WINDOW_RAM_STRIDE_EN
    assign w_stride = rd_stride;
`else
    assign w_stride = ADDR_W'(1);
`endif

    assign w_accept = (r_state == S_IDLE) && rd_en && !rst;
    assign w_wr_en  = wr_en && !rst;    // a write on a reset cycle is discarded
    assign w_rd_en  = (r_state == S_READ);

    // Request FSM with the ready and busy flags. Reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b0;
                    if (rd_en) begin
                        r_state <= S_READ;
                        r_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Latch the per-word addresses (wrapping at depth) when a request is accepted. Unused pad ports read address 0.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < N_PORT; i++) begin
                r_addr[i] <= (i < N_OUT) ?
                    ADDR_W'(win_offset(32'(rd_addr), 32'(w_stride), 32'(i))) : '0;
            end
        end
    end

    for (genvar p = 0; p < N_PORT; p++) begin : g_addr
        assign w_rd_addr[p*ADDR_W +: ADDR_W] = r_addr[p];
    end

    for (genvar b = 0; b < N_BANK; b++) begin : g_bank
        window_ram_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .N_RD   (RD_PER_BANK)
        ) u_bank (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_en   (w_rd_en),
            .i_rd_addr (w_rd_addr[b*RD_PER_BANK*ADDR_W +: RD_PER_BANK*ADDR_W]),
            .o_rd_data (w_rd_data[b*RD_PER_BANK*DATA_W +: RD_PER_BANK*DATA_W])
        );
    end

    assign data_out  = w_rd_data[N_OUT*DATA_W-1:0];
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_window_ram.sv
// tb_window_ram: directed bench for window_ram. It fills the memory with
// 0x1000+addr, then runs windows at base, wrap, stride, busy-drop,
// collision and mid-op reset points.
`timescale 1ns/1ps
module tb_window_ram;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 9;
  localparam int N_OUT  = 12;
  localparam int DEPTH  = 512;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rd_en;
  logic [ADDR_W-1:0]       rd_addr;
`ifdef WINDOW_RAM_STRIDE_EN
  logic [ADDR_W-1:0]       rd_stride;
`endif
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic [N_OUT*DATA_W-1:0] data_out;
  logic                    ready;
  logic                    busy;
  logic [1:0]              dbg_state;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model [DEPTH];
  int n_vec  = 0;
  int n_miss = 0;

  window_ram dut (
    .clk       (clk),
    .rst       (rst),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
`ifdef WINDOW_RAM_STRIDE_EN
    .rd_stride (rd_stride),
`endif
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .data_out  (data_out),
    .ready     (ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] word(input int i);
    return data_out[i*DATA_W +: DATA_W];
  endfunction

  task automatic set_stride(input logic [ADDR_W-1:0] s);
`ifdef WINDOW_RAM_STRIDE_EN
    rd_stride = s;
`else
    if (s != 1) $display("note: stride %0d ignored without stride support", s);
`endif
  endtask

  task automatic push_window(input int base, input int stride);
    for (int i = 0; i < N_OUT; i++) begin
      exp_q.push_back(model[(base + i * stride) % DEPTH]);
    end
  endtask

  task automatic drain_window(input string tag);
    for (int i = 0; i < N_OUT; i++) begin
      if (exp_q.size() == 0) begin
        check($sformatf("%s.q_empty", tag), 64'd0, 64'd1);
      end else begin
        check($sformatf("%s.w%0d", tag, i), word(i), exp_q.pop_front());
      end
    end
  endtask

  task automatic write_word(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    model[a] = d;
  endtask

  // One full request: accepted at E0, ready visible after E2. Optional write in the READ cycle.
  task automatic read_window(input int base, input int stride, input bit coll,
                             input int c_addr, input logic [DATA_W-1:0] c_data,
                             input string tag);
    push_window(base, stride);
    rd_addr = ADDR_W'(base);
    set_stride(ADDR_W'(stride));
    rd_en = 1'b1;
    tick();  // E0
    rd_en = 1'b0;
    if (coll) begin
      wr_en = 1'b1; wr_addr = ADDR_W'(c_addr); wr_data = c_data;
    end
    check({tag, ".busy_e0"}, 64'(busy), 64'd1);
    check({tag, ".rdy_e0"}, 64'(ready), 64'd0);
    check({tag, ".st_e0"}, 64'(dbg_state), 64'd1);
    tick();  // E1
    if (coll) begin
      wr_en = 1'b0;
      model[c_addr] = c_data;
    end
    check({tag, ".busy_e1"}, 64'(busy), 64'd1);
    check({tag, ".rdy_e1"}, 64'(ready), 64'd0);
    tick();  // E2
    check({tag, ".rdy_e2"}, 64'(ready), 64'd1);
    check({tag, ".busy_e2"}, 64'(busy), 64'd0);
    drain_window(tag);
  endtask

  initial begin : main
    int pulses;
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_data = '0;
    set_stride(ADDR_W'(1));

    // reset
    tick(); tick();
    check("rst.data_out", 64'(|data_out), 64'd0);
    check("rst.ready", 64'(ready), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < DEPTH; k++) write_word(k, 64'h1000 + 64'(k));

    read_window(0, 1, 1'b0, 0, '0, "base0");
    check("base0.hand_w11", word(11), 64'h100B);

    read_window(507, 1, 1'b0, 0, '0, "wrap");
    check("wrap.hand_w0", word(0), 64'h11FB);
    check("wrap.hand_w4", word(4), 64'h11FF);
    check("wrap.hand_w5", word(5), 64'h1000);
    check("wrap.hand_w11", word(11), 64'h1006);

`ifdef WINDOW_RAM_STRIDE_EN
    read_window(10, 3, 1'b0, 0, '0, "stride3");
    check("stride3.hand_w1", word(1), 64'h100D);
    check("stride3.hand_w11", word(11), 64'h102B);
    read_window(10, 0, 1'b0, 0, '0, "stride0");
    check("stride0.hand_w0", word(0), 64'h100A);
    check("stride0.hand_w11", word(11), 64'h100A);
    set_stride(ADDR_W'(1));
`endif

    // busy drop: second request at E1 must be ignored
    push_window(30, 1);
    rd_addr = ADDR_W'(30); rd_en = 1'b1;
    tick();  // E0
    rd_addr = ADDR_W'(100);
    check("drop.busy_e0", 64'(busy), 64'd1);
    tick();  // E1, rd_en still high
    rd_en = 1'b0;
    check("drop.busy_e1", 64'(busy), 64'd1);
    check("drop.rdy_e1", 64'(ready), 64'd0);
    tick();  // E2
    check("drop.rdy_e2", 64'(ready), 64'd1);
    drain_window("drop");
    check("drop.hand_w0", word(0), 64'h101E);
    pulses = 0;
    repeat (4) begin
      tick();
      if (ready) pulses++;
      if (busy) pulses += 100;
    end
    check("drop.extra_activity", 64'(pulses), 64'd0);
    check("drop.hold_w0", word(0), 64'h101E);

    // collision: read-first on addr 5 during READ, then new data visible
    read_window(0, 1, 1'b1, 5, 64'hDEAD, "coll");
    check("coll.hand_w5_old", word(5), 64'h1005);
    read_window(0, 1, 1'b0, 0, '0, "coll_next");
    check("coll_next.hand_w5", word(5), 64'hDEAD);

    // mid-op reset on the READ cycle, with a write that must be discarded
    rd_addr = ADDR_W'(20); rd_en = 1'b1;
    tick();  // E0
    rd_en = 1'b0;
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = ADDR_W'(7); wr_data = 64'hBAD;
    tick();  // E1 under reset
    rst = 1'b0; wr_en = 1'b0;
    check("midrst.data_out", 64'(|data_out), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.state", 64'(dbg_state), 64'd0);
    pulses = 0;
    repeat (4) begin
      tick();
      if (ready) pulses++;
    end
    check("midrst.no_ready", 64'(pulses), 64'd0);
    read_window(0, 1, 1'b0, 0, '0, "after_rst");
    check("after_rst.hand_w7", word(7), 64'h1007);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
